// File: rtl/m_sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : m_sel_pkg
//  Description : Shared constants and helpers for the priority selector family.
//  Revision    : 1.0 - initial release
// ============================================================================
package m_sel_pkg;

    // Arbitration mode encodings
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Index width that never collapses to zero bits, even for tiny N
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_prio_arb.sv
`default_nettype none
// ============================================================================
//  Module      : m_prio_arb
//  Description : Combinational rotating-priority search. The first requester
//                found scanning upward from i_ptr (with wrap) wins. Tying
//                i_ptr to zero gives plain lowest-index-wins priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module m_prio_arb
    import m_sel_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [CW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [CW-1:0] o_idx
);

    logic w_found;
    int   w_cand;

    // Scan N candidates starting at the pointer; first request found wins
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < N; k++) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (!w_found && i_req[w_cand]) begin
                w_found        = 1'b1;
                o_gnt[w_cand]  = 1'b1;
                o_idx          = CW'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/m_prio_sel.sv
`default_nettype none
// ============================================================================
//  Module      : m_prio_sel
//  Description : N-channel, W-bit priority selector with a registered output
//                stage and valid/ready handshake. Fixed-priority or
//                round-robin arbitration chosen at elaboration time.
//  Revision    : 1.0 - initial release
// ============================================================================
module m_prio_sel
    import m_sel_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    parameter  int MODE = MODE_FIXED,
    localparam int CW   = idx_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [CW-1:0]  out_chan
);

    logic           r_out_valid;
    logic [W-1:0]   r_out_data;
    logic [CW-1:0]  r_out_chan;

    logic           w_out_valid_nxt;
    logic [W-1:0]   w_out_data_nxt;
    logic [CW-1:0]  w_out_chan_nxt;

    logic [N-1:0]   w_gnt;
    logic [CW-1:0]  w_idx;
    logic [CW-1:0]  w_ptr;
    logic           w_load;
    logic [W-1:0]   w_sel_data;

    // A new word is taken whenever the output slot is empty or draining
    assign w_load = (~r_out_valid | out_ready) & (|in_valid);

    // Grant goes out only on a load; held low while reset is asserted
    always_comb begin
        in_ready = '0;
        if (w_load && rst_n) begin
            in_ready = w_gnt;
        end
    end

    m_prio_arb #(
        .N  (N),
        .CW (CW)
    ) u_arb (
        .i_req (in_valid),
        .i_ptr (w_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [CW-1:0] r_ptr;
            logic [CW-1:0] w_ptr_nxt;

            // Pointer moves just past the last granted channel
            always_comb begin
                w_ptr_nxt = r_ptr;
                if (w_load) begin
                    w_ptr_nxt = (w_idx == CW'(N - 1)) ? '0 : w_idx + 1'b1;
                end
            end

            // Round-robin pointer register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_ptr_nxt;
                end
            end

            assign w_ptr = r_ptr;
        end else begin : g_fixed
            assign w_ptr = '0;
        end
    endgenerate

    // One-hot grant selects the winning channel's word
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = in_data[i*W +: W];
            end
        end
    end

    // Output slot: load, drain, or hold; data/chan keep last word when idle
    always_comb begin
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_chan_nxt  = r_out_chan;
        if (w_load) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = w_sel_data;
            w_out_chan_nxt  = w_idx;
        end else if (out_ready) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    // Output register; a pending word is dropped by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else begin
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_chan  <= w_out_chan_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule
`default_nettype wire

// File: tb/tb_m_prio_sel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m_prio_sel
//  Description : Self-checking bench for m_prio_sel, fixed and round-robin
//                instances side by side against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m_prio_sel;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic           out_ready;

    logic [N-1:0]   rdy_f, rdy_r;
    logic           ov_f, ov_r;
    logic [W-1:0]   od_f, od_r;
    logic [1:0]     oc_f, oc_r;

    int tests = 0;
    int fails = 0;

    // Model state, index 0 = fixed instance, 1 = round-robin instance
    logic       m_valid [2];
    logic [7:0] m_data  [2];
    int         m_chan  [2];
    int         m_ptr   [2];

    m_prio_sel #(.N(N), .W(W), .MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_f), .out_valid(ov_f), .out_ready(out_ready),
        .out_data(od_f), .out_chan(oc_f)
    );

    m_prio_sel #(.N(N), .W(W), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_r), .out_valid(ov_r), .out_ready(out_ready),
        .out_data(od_r), .out_chan(oc_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Winner from the rules: fixed = lowest requester; rr = first at or after p, wrapping
    function automatic int winner(input int mode, input logic [N-1:0] v, input int p);
        int start;
        start = (mode == 1) ? p : 0;
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] chan_data(input int c);
        return in_data[c*W +: W];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = 8'h00;
            m_chan[k]  = 0;
            m_ptr[k]   = 0;
        end
    endtask

    // One clock: check grants, advance the model, check registered outputs.
    // Entered and left 1 time unit after a rising edge.
    task automatic cycle();
        int         w   [2];
        logic       ld  [2];
        logic [3:0] exp_rdy;
        logic [3:0] act_rdy;
        #1;
        for (int k = 0; k < 2; k++) begin
            w[k]    = winner(k, in_valid, m_ptr[k]);
            ld[k]   = (!m_valid[k] || out_ready) && (in_valid != 4'b0000);
            exp_rdy = ld[k] ? (4'b0001 << w[k]) : 4'b0000;
            act_rdy = (k == 0) ? rdy_f : rdy_r;
            tests++;
            if (act_rdy !== exp_rdy) begin
                fails++;
                $display("FAIL in_ready mode%0d t=%0t got %b expected %b", k, $time, act_rdy, exp_rdy);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (ld[k]) begin
                m_valid[k] = 1'b1;
                m_data[k]  = chan_data(w[k]);
                m_chan[k]  = w[k];
                m_ptr[k]   = (w[k] + 1) % N;
            end else if (out_ready) begin
                m_valid[k] = 1'b0;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (((k == 0) ? ov_f : ov_r) !== m_valid[k]) begin
                fails++;
                $display("FAIL out_valid mode%0d t=%0t got %b expected %b", k, $time, (k == 0) ? ov_f : ov_r, m_valid[k]);
            end
            tests++;
            if (((k == 0) ? od_f : od_r) !== m_data[k]) begin
                fails++;
                $display("FAIL out_data mode%0d t=%0t got %h expected %h", k, $time, (k == 0) ? od_f : od_r, m_data[k]);
            end
            tests++;
            if (int'((k == 0) ? oc_f : oc_r) != m_chan[k]) begin
                fails++;
                $display("FAIL out_chan mode%0d t=%0t got %0d expected %0d", k, $time, (k == 0) ? oc_f : oc_r, m_chan[k]);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = 32'h0403_0201;
        out_ready = 1'b1;
        model_clear();
        #2;
        tests++;
        if (rdy_f !== 4'b0000 || rdy_r !== 4'b0000) begin
            fails++;
            $display("FAIL reset_in_ready got %b/%b expected 0000", rdy_f, rdy_r);
        end
        tests++;
        if (ov_f !== 1'b0 || od_f !== 8'h00 || oc_f !== 2'd0) begin
            fails++;
            $display("FAIL reset_outputs got v=%b d=%h c=%0d expected 0/00/0", ov_f, od_f, oc_f);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Load a word from ch2 and stall it, then reset mid-cycle
        in_valid  = 4'b0100;
        in_data   = 32'h00C2_0000;
        out_ready = 1'b0;
        cycle();
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if (ov_f !== 1'b0 || od_f !== 8'h00 || oc_f !== 2'd0 || ov_r !== 1'b0 || oc_r !== 2'd0) begin
            fails++;
            $display("FAIL async_reset got v=%b d=%h c=%0d rr v=%b c=%0d expected all zero", ov_f, od_f, oc_f, ov_r, oc_r);
        end
        tests++;
        if (rdy_f !== 4'b0000 || rdy_r !== 4'b0000) begin
            fails++;
            $display("FAIL async_reset_in_ready got %b/%b expected 0000", rdy_f, rdy_r);
        end
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        do_reset();
        in_valid  = 4'b1010;
        in_data   = 32'h3300_1100;
        out_ready = 1'b1;
        #1;
        tests++;
        if (rdy_f !== 4'b0010) begin
            fails++;
            $display("FAIL fixed_grant got %b expected 0010", rdy_f);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            tests++;
            if (od_f !== 8'h11 || oc_f !== 2'd1) begin
                fails++;
                $display("FAIL fixed_repeat got d=%h c=%0d expected 11/1", od_f, oc_f);
            end
        end
    endtask

    task automatic test_rr_sequence();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        do_reset();
        in_valid  = 4'b1111;
        in_data   = 32'hA3A2_A1A0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            tests++;
            if (ov_r !== 1'b1 || int'(oc_r) != exp_seq[i] || od_r !== 8'(8'hA0 + exp_seq[i])) begin
                fails++;
                $display("FAIL rr_sequence step%0d got v=%b c=%0d d=%h expected 1/%0d", i, ov_r, oc_r, od_r, exp_seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid  = 4'b0001;
        in_data   = 32'h0000_0055;
        out_ready = 1'b1;
        cycle();
        in_valid  = 4'b0100;
        in_data   = 32'h00C2_0055;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (rdy_f !== 4'b0000) begin
                fails++;
                $display("FAIL stall_in_ready got %b expected 0000", rdy_f);
            end
            cycle();
            tests++;
            if (ov_f !== 1'b1 || od_f !== 8'h55) begin
                fails++;
                $display("FAIL stall_hold got v=%b d=%h expected 1/55", ov_f, od_f);
            end
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (rdy_f !== 4'b0100) begin
            fails++;
            $display("FAIL stall_release got %b expected 0100", rdy_f);
        end
        cycle();
        tests++;
        if (od_f !== 8'hC2 || oc_f !== 2'd2) begin
            fails++;
            $display("FAIL stall_release_data got d=%h c=%0d expected C2/2", od_f, oc_f);
        end
    endtask

    task automatic test_hold_last();
        do_reset();
        in_valid  = 4'b0001;
        in_data   = 32'h0000_007E;
        out_ready = 1'b1;
        cycle();
        in_valid = 4'b0000;
        in_data  = 32'h0000_0000;
        for (int i = 0; i < 10; i++) begin
            cycle();
            tests++;
            if (ov_f !== 1'b0 || od_f !== 8'h7E) begin
                fails++;
                $display("FAIL hold_last cyc%0d got v=%b d=%h expected 0/7E", i, ov_f, od_f);
            end
        end
    endtask

    task automatic test_rr_wrap();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        in_data   = 32'h0022_1100;
        cycle();
        in_valid = 4'b0011;
        #1;
        tests++;
        if (rdy_r !== 4'b0001) begin
            fails++;
            $display("FAIL rr_wrap_first got %b expected 0001", rdy_r);
        end
        cycle();
        tests++;
        if (oc_r !== 2'd0) begin
            fails++;
            $display("FAIL rr_wrap_chan got %0d expected 0", oc_r);
        end
        #1;
        tests++;
        if (rdy_r !== 4'b0010) begin
            fails++;
            $display("FAIL rr_wrap_second got %b expected 0010", rdy_r);
        end
        cycle();
        tests++;
        if (oc_r !== 2'd1) begin
            fails++;
            $display("FAIL rr_wrap_chan2 got %0d expected 1", oc_r);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom_range(0, 15));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_sequence();
        test_backpressure();
        test_hold_last();
        test_rr_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m_prio_sel.md
Name: m_prio_sel

Overview:
- Parametrised N-channel, W-bit priority selector with a registered output stage and a valid/ready handshake.
- Successor to the combinational if/else-if selectors. The "hold last value when nothing is selected" behaviour becomes an explicit register instead of an inferred latch.
- Adds a runtime-free choice between fixed-priority and round-robin arbitration.
- Sits between several producer channels and one downstream consumer in datapath examples.

Parameters:
- N, 4, number of input channels (≥2).
- W, 8, data width per channel (≥1).
- MODE, 0, arbitration: 0 = fixed priority (lowest index wins), 1 = round-robin.
- CW, $clog2(N), channel index width. Derived local parameter, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-channel request; bit i belongs to channel i.
- in_data  input  N*W  packed channel data; channel i is in_data[i*W +: W].
- in_ready  output  N  one-hot grant; channel i's word is consumed this cycle.
- out_valid  output  1  out_data/out_chan hold an unconsumed word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  W  selected data; holds the last accepted value.
- out_chan  output  CW  index of the channel that supplied out_data.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low. It acts immediately, independent of clk.
  - out_valid=0, out_data=0, out_chan=0, RR pointer=0.
  - in_ready=0 while rst_n=0.
- Load condition: load = (~out_valid | out_ready) & (|in_valid).
- in_ready:
  - Combinational, one-hot or zero. Asserted only for the winning channel, and only when load=1.
  - Never depends combinationally on in_data.
- Fixed mode (MODE=0): the winner is the lowest index i with in_valid[i]=1.
- Round-robin mode (MODE=1):
  - Search starts at the RR pointer p and runs upward with wrap-around (p, p+1, …, N-1, 0, …, p-1). The first requesting channel wins.
  - After a grant to channel g: p <= (g==N-1) ? 0 : g+1.
  - p is unchanged on cycles with no grant.
- Registered output:
  - On load, at the next edge: out_data <= winner data, out_chan <= winner index, out_valid <= 1.
  - Latency is 1 cycle from grant to out_valid.
- Output consumption and stall:
  - out_valid && out_ready && no new load: out_valid <= 0. out_data and out_chan keep their values; no latch and no X.
  - out_valid && !out_ready: everything holds, and in_ready=0 on all channels (stall).
- Simultaneous drain and refill: when out_ready=1 and a new request arrives in the same cycle, the new word loads immediately. Full throughput is 1 word/cycle.
- No requests: out_valid falls after consumption. out_data retains the last word, the registered equivalent of the "no else" branch.
- Upstream contract: a channel must keep in_valid/in_data stable until its in_ready is seen. The block does not check this.
- Single requester: in both modes the sole requester wins every cycle the output is free.
- Reset mid-transfer: a pending out_valid word is dropped. Upstream must re-present it.

Decomposition:
- Shared package m_sel_pkg:
  - MODE encodings as localparams MODE_FIXED=0, MODE_RR=1.
  - A clog2-safe index-width helper.
- One natural sub-module: m_prio_arb.
  - Combinational priority/rotating-priority search.
  - Inputs: request vector and start pointer. Outputs: one-hot grant and encoded index.
  - Fixed mode is instantiated with pointer tied to 0.
- The top level holds the RR pointer, the output register and the handshake.

Test Plan:
- Use N=4, W=8.
- Reset: assert rst_n=0 mid-cycle with out_valid=1 -> out_valid=0, out_data=0x00 and out_chan=0 immediately, before the next clk edge.
- Fixed mode, in_valid=4'b1010, data ch1=0x11 and ch3=0x33, out_ready=1:
  - in_ready=4'b0010; next cycle out_data=0x11, out_chan=1.
  - With requests held, ch1 wins again every cycle.
- Round-robin mode, all four valid, data 0xA0..0xA3, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
- Backpressure: out_valid=1 with 0x55, out_ready=0 for 3 cycles, in_valid=4'b0100 -> in_ready=0 throughout and out_data stays 0x55. On the cycle out_ready=1, ch2 is granted.
- Hold-last: after 0x7E is consumed with no further requests -> out_valid=0 and out_data remains 0x7E for 10 cycles.
- Round-robin wrap: p=3, in_valid=4'b0011 -> ch0 wins and p becomes 1. Next grant with the same requests goes to ch1.
